// File: rtl/gcd_pkg.sv
// gcd_pkg: shared FSM encoding and operand width for gcd_arb
package gcd_pkg;
  localparam int OPW = 8;
  typedef enum logic [1:0] {IDLE, LOAD, BUSY, RESP} state_t;
endpackage

// File: rtl/gcd_arb_if.sv
// gcd_arb_if: request/response bundle between requesters and the gcd arbiter
interface gcd_arb_if import gcd_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IDW = $clog2(NREQ)
) ();
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [OPW*NREQ-1:0] req_a;
  logic [OPW*NREQ-1:0] req_b;
  logic rsp_valid;
  logic rsp_ready;
  logic [OPW-1:0] rsp_q;
  logic [IDW-1:0] rsp_id;
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input req_ready, rsp_valid, rsp_q, rsp_id
  );
  modport slave (
    input req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_q, rsp_id
  );
endinterface

// File: rtl/gcd_arb_gcd.sv
// gcd_engine: subtractive gcd core; rdy flags the cycle q holds the result
module gcd_engine import gcd_pkg::*; (
  input logic clk,
  input logic rst,
  input logic ld,
  input logic [OPW-1:0] a,
  input logic [OPW-1:0] b,
  output logic [OPW-1:0] q,
  output logic rdy
);
  logic [OPW-1:0] x, y;
  logic run;
  assign q = x;
  assign rdy = run && x == y;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x <= '0;
      y <= '0;
      run <= 1'b0;
    end else if (ld) begin
      x <= a;
      y <= b;
      run <= 1'b1;
    end else if (run) begin
      run <= x != y;
      if (x > y) x <= x - y;
      else if (y > x) y <= y - x;
    end
endmodule

// File: rtl/gcd_arb.sv
// gcd_arb: round-robin arbiter sharing one gcd engine among NREQ requesters
module gcd_arb import gcd_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IDW = $clog2(NREQ)
) (
  input logic clk,
  input logic reset,
  gcd_arb_if.slave bus
);
  state_t state, state_nx;
  logic [IDW-1:0] last, gnt_id, id, j;
  logic [OPW-1:0] a, b, sel_a, sel_b, q, rsp_q;
  logic [NREQ-1:0] gnt;
  logic gnt_any, zero, ld, rdy, rsp_valid;
  // first valid requester after the last grant wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_id = '0;
    j = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = IDW'((int'(last) + k) % NREQ);
      if (!gnt_any && bus.req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_id = j;
      end
    end
  end
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    gnt = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt_id == IDW'(i)) begin
        sel_a = bus.req_a[OPW*i +: OPW];
        sel_b = bus.req_b[OPW*i +: OPW];
        gnt[i] = gnt_any;
      end
  end
  assign zero = sel_a == '0 || sel_b == '0;
  always_comb begin
    ld = state == LOAD;
    state_nx = state == IDLE ? (gnt_any ? (zero ? RESP : LOAD) : IDLE)
             : state == LOAD ? BUSY
             : state == BUSY ? (rdy ? RESP : BUSY)
             : (rsp_valid && bus.rsp_ready ? IDLE : RESP);
  end
  // zero operands skip the engine: gcd(x,0) = x|0
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      last <= IDW'(NREQ - 1);
      id <= '0;
      a <= '0;
      b <= '0;
      rsp_q <= '0;
      rsp_valid <= 1'b0;
    end else begin
      state <= state_nx;
      rsp_valid <= state_nx == RESP;
      if (state == IDLE && gnt_any) begin
        last <= gnt_id;
        id <= gnt_id;
        a <= sel_a;
        b <= sel_b;
        rsp_q <= sel_a | sel_b;
      end
      if (state == BUSY && rdy) rsp_q <= q;
    end
  assign bus.req_ready = reset && state == IDLE ? gnt : '0;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_q = rsp_q;
  assign bus.rsp_id = id;
  gcd_engine u_gcd (
    .clk(clk),
    .rst(~reset),
    .ld(ld),
    .a(a),
    .b(b),
    .q(q),
    .rdy(rdy)
  );
endmodule

// File: tb/tb_gcd_arb.sv
// tb_gcd_arb: table vectors, corner sequences and random traffic against a gcd/round-robin model
module tb_gcd_arb;
  import gcd_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  typedef struct { int id; int a; int b; int q; bit byp; } vec_t;
  typedef struct { int id; int q; } rsp_t;
  vec_t vecs [8];
  rsp_t exp_q [$];
  gcd_arb_if #(.NREQ(N)) bus ();
  gcd_arb #(.NREQ(N)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic int gcd_ref(int x, int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction
  function automatic int rnd_op();
    return $urandom_range(0, 4) == 0 ? 0 : int'($urandom_range(1, 255));
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
  endtask
  task automatic set_req(input int i, input int x, input int y);
    bus.req_valid[i] = 1'b1;
    bus.req_a[8*i +: 8] = 8'(x);
    bus.req_b[8*i +: 8] = 8'(y);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic wait_rsp(output int lat, output int lds);
    lat = 1;
    lds = 0;
    while (!bus.rsp_valid && lat < 400) begin
      lds += int'(dut.ld);
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic run_one(input vec_t v);
    int lat, lds;
    set_req(v.id, v.a, v.b);
    #1 chk("grant", bus.req_ready, 1 << v.id);
    @(negedge clk);
    bus.req_valid[v.id] = 1'b0;
    wait_rsp(lat, lds);
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_q", bus.rsp_q, v.q);
    chk("rsp_id", bus.rsp_id, v.id);
    chk("ld_cycles", lds, v.byp ? 0 : 1);
    if (v.byp) chk("bypass_lat", lat, 1);
    else chk("lat_min", lat >= 3, 1);
    @(negedge clk);
    chk("rsp_drop", bus.rsp_valid, 0);
  endtask
  initial begin
    int got, lat, lds, g, ptr, busy_cnt, nresp;
    logic busy;
    logic [N-1:0] pend;
    int pa [N];
    int pb [N];
    vecs[0] = '{2, 48, 18, 6, 1'b0};
    vecs[1] = '{1, 0, 35, 35, 1'b1};
    vecs[2] = '{1, 0, 0, 0, 1'b1};
    vecs[3] = '{0, 255, 1, 1, 1'b0};
    vecs[4] = '{3, 17, 17, 17, 1'b0};
    vecs[5] = '{0, 100, 75, 25, 1'b0};
    vecs[6] = '{2, 7, 0, 7, 1'b1};
    vecs[7] = '{3, 128, 96, 32, 1'b0};
    idle_inputs();
    repeat (2) @(negedge clk);
    bus.req_valid = '1;
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_q", bus.rsp_q, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    foreach (vecs[i]) run_one(vecs[i]);
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 12, 8);
    got = 0;
    for (int c = 0; c < 2000 && got < 5; c++) begin
      #1;
      if (bus.rsp_valid) begin
        chk($sformatf("rr_id%0d", got), bus.rsp_id, got % N);
        chk("rr_q", bus.rsp_q, 4);
        got++;
      end
      @(negedge clk);
    end
    chk("rr_count", got, 5);
    do_reset();
    bus.rsp_ready = 1'b0;
    set_req(2, 48, 18);
    @(negedge clk);
    bus.req_valid = '0;
    wait_rsp(lat, lds);
    chk("stall_ld", lds, 1);
    set_req(0, 5, 5);
    set_req(1, 9, 3);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_valid", bus.rsp_valid, 1);
      chk("stall_q", bus.rsp_q, 6);
      chk("stall_id", bus.rsp_id, 2);
      chk("stall_req_ready", bus.req_ready, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1 chk("post_stall_grant", bus.req_ready, 4'b0001);
    do_reset();
    set_req(1, 255, 1);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (5) @(negedge clk);
    set_req(0, 30, 12);
    set_req(3, 21, 14);
    reset = 1'b0;
    #1;
    chk("midrst_req_ready", bus.req_ready, 0);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_rsp_q", bus.rsp_q, 0);
    chk("midrst_rsp_id", bus.rsp_id, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("midrst_first_grant", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    wait_rsp(lat, lds);
    chk("midrst_rsp_id", bus.rsp_id, 0);
    chk("midrst_rsp_q", bus.rsp_q, 6);
    do_reset();
    ptr = N - 1;
    busy = 1'b0;
    pend = '0;
    busy_cnt = 0;
    nresp = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          pa[i] = rnd_op();
          pb[i] = rnd_op();
        end else if (pend[i] && $urandom_range(0, 19) == 0) pend[i] = 1'b0;
        bus.req_a[8*i +: 8] = 8'(pa[i]);
        bus.req_b[8*i +: 8] = 8'(pb[i]);
      end
      bus.req_valid = pend;
      bus.rsp_ready = $urandom_range(0, 2) != 0;
      #1;
      g = -1;
      if (!busy)
        for (int k = 1; k <= N; k++)
          if (g < 0 && pend[(ptr + k) % N]) g = (ptr + k) % N;
      chk("rand_grant", bus.req_ready, g < 0 ? 0 : 1 << g);
      if (bus.rsp_valid && exp_q.size() == 0) chk("rand_spurious", bus.rsp_valid, 0);
      else if (bus.rsp_valid) begin
        chk("rand_q", bus.rsp_q, exp_q[0].q);
        chk("rand_id", bus.rsp_id, exp_q[0].id);
        if (bus.rsp_ready) begin
          void'(exp_q.pop_front());
          busy = 1'b0;
          nresp++;
        end
      end
      if (g >= 0) begin
        pend[g] = 1'b0;
        busy = 1'b1;
        ptr = g;
        exp_q.push_back('{g, gcd_ref(pa[g], pb[g])});
      end
      busy_cnt = busy ? busy_cnt + 1 : 0;
      if (busy_cnt > 600) begin
        chk("rand_timeout", busy_cnt, 0);
        break;
      end
      @(negedge clk);
    end
    chk("rand_responses", nresp > 20, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gcd_arb.md
GCD_ARB -- requirements
Module: gcd_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters (legal 2..8).
REQ-002 The block SHALL have parameter IDW, default $clog2(NREQ), meaning the response tag width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, input, NREQ bits, one request-valid per requester.
REQ-006 The block SHALL have port req_a, input, 8*NREQ bits, operand a; requester i owns bits [8i+7:8i].
REQ-007 The block SHALL have port req_b, input, 8*NREQ bits, operand b, packed as req_a.
REQ-008 The block SHALL have port req_ready, output, NREQ bits, one-hot single-cycle accept pulse.
REQ-009 The block SHALL have port rsp_valid, output, 1 bit, result available.
REQ-010 The block SHALL have port rsp_q, output, 8 bits, gcd result.
REQ-011 The block SHALL have port rsp_id, output, IDW bits, index of the requester that owns rsp_q.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit, consumer accepts the result.

Function
REQ-013 The block SHALL share one internal gcd engine among NREQ requesters, one operation in flight.
REQ-014 The FSM SHALL have exactly four states: IDLE, LOAD, BUSY and RESP.
REQ-015 In IDLE with any req_valid high, the block SHALL grant round-robin: search starts at (last granted + 1) mod NREQ.
REQ-016 On grant, the block SHALL pulse req_ready[i] for one cycle and capture req_a[i], req_b[i] and i.
REQ-017 Requesters SHALL hold valid and operands until req_ready; the block SHALL NOT accept while not in IDLE.
REQ-018 If captured a==0 or b==0, the next state SHALL be RESP with rsp_q = a|b (bypass); ld is never asserted.
REQ-019 Otherwise the next state SHALL be LOAD, which drives the engine ld high for exactly one cycle with the captured operands, then BUSY.
REQ-020 BUSY SHALL wait for engine rdy, capture engine q on that cycle into rsp_q, then go to RESP.
REQ-021 In RESP, rsp_valid SHALL be 1 and rsp_q/rsp_id SHALL be stable; on rsp_valid & rsp_ready the next state SHALL be IDLE.
REQ-022 rsp_valid SHALL be registered; a new grant occurs earliest in the cycle after the response handshake.
REQ-023 Latency: accept at cycle T; LOAD at T+1; rsp_valid the cycle after engine rdy; bypass rsp_valid at T+1.
REQ-024 Requests deasserted without acceptance SHALL be ignored; the pointer SHALL advance only on a grant.

Reset
REQ-025 While reset is low: state IDLE, pointer such that requester 0 has top priority, req_ready=0, rsp_valid=0, rsp_q=0, rsp_id=0.
REQ-026 Reset mid-operation SHALL abandon the operation without producing a response; the engine SHALL be reset by the same event, driven with ~reset.

Structure
REQ-027 State encodings and the operand width constant (8) SHALL live in a shared package, gcd_pkg.
REQ-028 The single sub-module SHALL be the existing gcd engine, instance name u_gcd.

Verification
REQ-029 Requester 2 sends a=48, b=18 -> one req_ready[2] pulse, then rsp_q=6, rsp_id=2, ld high exactly one cycle.
REQ-030 All four requesters valid continuously (a=12,b=8) -> responses carry rsp_id 0,1,2,3,0 in that order, each rsp_q=4.
REQ-031 Requester 1 sends a=0, b=35 -> rsp_valid at T+1, rsp_q=35, rsp_id=1, ld never asserted; a=0, b=0 -> rsp_q=0.
REQ-032 rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_q and rsp_id stable, req_ready stays 0.
REQ-033 Reset asserted during BUSY -> all outputs 0 immediately, no response; after release, requesters 0 and 3 valid -> 0 granted first.
